// File: rtl/pipeline_stall_controller_pkg.sv
// Shared pipeline-control definitions: FSM state encodings, request priority
// and the canonical enable/bubble patterns driven by the stall controller.
package pipeline_stall_controller_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_FLUSH    = 2'b10
    } pipe_state_e;

    // Encoded value doubles as priority: a larger code wins.
    typedef enum logic [1:0] {
        REQ_NONE = 2'b00,
        REQ_BR   = 2'b01,
        REQ_LU   = 2'b10,
        REQ_MEM  = 2'b11
    } pipe_req_e;

    typedef struct packed {
        logic le_pc;
        logic le_if_id;
        logic flush_if_id;
        logic nop;
        logic le_id_ex;
        logic le_ex_mem;
        logic wb_nop;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_RUN = '{
        le_pc: 1'b1, le_if_id: 1'b1, flush_if_id: 1'b0, nop: 1'b1,
        le_id_ex: 1'b1, le_ex_mem: 1'b1, wb_nop: 1'b0
    };

    localparam pipe_ctrl_t CTRL_RESET = '{
        le_pc: 1'b0, le_if_id: 1'b0, flush_if_id: 1'b1, nop: 1'b0,
        le_id_ex: 1'b0, le_ex_mem: 1'b0, wb_nop: 1'b1
    };

    localparam pipe_ctrl_t CTRL_FREEZE = '{
        le_pc: 1'b0, le_if_id: 1'b0, flush_if_id: 1'b0, nop: 1'b1,
        le_id_ex: 1'b0, le_ex_mem: 1'b0, wb_nop: 1'b1
    };

    function automatic pipe_req_e resolve_req(input logic mem_busy,
                                              input logic load_use,
                                              input logic br_taken);
        if (mem_busy) return REQ_MEM;
        if (load_use) return REQ_LU;
        if (br_taken) return REQ_BR;
        return REQ_NONE;
    endfunction

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Control-path bundle between the hazard/memory side (master) and the stall
// controller (slave). Valid/ready is not used: every signal is level-sampled each cycle.
interface pipeline_stall_controller_if #(
    parameter int STAT_W = 16
);
    import pipeline_stall_controller_pkg::*;

    logic              hz_load_use;
    logic              br_taken;
    logic              mem_busy;
    logic              LE_PC;
    logic              LE_IF_ID;
    logic              FLUSH_IF_ID;
    logic              NOP;
    logic              LE_ID_EX;
    logic              LE_EX_MEM;
    logic              WB_NOP;
    logic              mem_timeout;
    logic [STAT_W-1:0] stall_cycles;
    logic [STAT_W-1:0] flush_count;
    pipe_state_e       dbg_state;

    modport master (
        output hz_load_use, br_taken, mem_busy,
        input  LE_PC, LE_IF_ID, FLUSH_IF_ID, NOP, LE_ID_EX, LE_EX_MEM, WB_NOP,
        input  mem_timeout, stall_cycles, flush_count, dbg_state
    );

    modport slave (
        input  hz_load_use, br_taken, mem_busy,
        output LE_PC, LE_IF_ID, FLUSH_IF_ID, NOP, LE_ID_EX, LE_EX_MEM, WB_NOP,
        output mem_timeout, stall_cycles, flush_count, dbg_state
    );

endinterface

// File: rtl/sat_event_counter.sv
// Event counter that sticks at all-ones instead of wrapping; cleared by the
// synchronous reset.
module sat_event_counter #(
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_inc,
    output logic [STAT_W-1:0] o_count
);

    logic [STAT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {STAT_W{1'b1}})) begin
            r_count <= r_count + STAT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline-register enable sequencer for the 5-stage core (RUN / MEM_WAIT / FLUSH).
// Optional stall statistics are built only when STALL_STATS_EN is defined.
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int MAX_MEM_WAIT = 8,
    parameter int BR_FLUSH_CYC = 1,
    parameter int CNT_W        = 4,
    parameter int STAT_W       = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    pipeline_stall_controller_if.slave  bus
);

    localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(BR_FLUSH_CYC - 1);
    localparam logic [CNT_W:0]   WAIT_LIMIT = (CNT_W + 1)'(MAX_MEM_WAIT);

    pipe_state_e      r_state;
    pipe_state_e      w_state_nxt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_nxt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] w_flush_cnt_nxt;
    logic [CNT_W:0]   w_wait_inc;
    logic             r_timeout;
    logic             w_timeout_set;
    logic             w_flush_pend;
    logic             w_br_accept;
    pipe_req_e        w_req;
    pipe_ctrl_t       w_ctrl;

    assign w_req      = resolve_req(bus.mem_busy, bus.hz_load_use, bus.br_taken);
    assign w_wait_inc = {1'b0, r_wait_cnt} + (CNT_W + 1)'(1);

    // A non-zero flush count means a flush is running or suspended by a memory
    // wait; a new branch is not accepted until it has drained.
    assign w_flush_pend = (r_flush_cnt != '0);
    assign w_br_accept  = !reset && (w_req == REQ_BR) && !w_flush_pend;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_wait_cnt  <= '0;
            r_flush_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            if (w_timeout_set) begin
                r_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_flush_cnt_nxt = r_flush_cnt;
        w_timeout_set   = 1'b0;
        w_ctrl          = CTRL_RUN;
        if (reset) begin
            w_ctrl          = CTRL_RESET;
            w_state_nxt     = ST_RUN;
            w_wait_cnt_nxt  = '0;
            w_flush_cnt_nxt = '0;
        end else if (w_req == REQ_MEM) begin
            // Flush count is left untouched so a suspended flush resumes intact.
            w_ctrl         = CTRL_FREEZE;
            w_state_nxt    = ST_MEM_WAIT;
            w_timeout_set  = (w_wait_inc >= WAIT_LIMIT);
            w_wait_cnt_nxt = w_timeout_set ? WAIT_LIMIT[CNT_W-1:0] : w_wait_inc[CNT_W-1:0];
        end else if (r_state == ST_FLUSH) begin
            w_ctrl.flush_if_id = 1'b1;
            w_flush_cnt_nxt    = r_flush_cnt - CNT_W'(1);
            w_state_nxt        = (r_flush_cnt == CNT_W'(1)) ? ST_RUN : ST_FLUSH;
        end else begin
            // RUN, or the release cycle of a memory wait: plain RUN decoding.
            w_wait_cnt_nxt = '0;
            w_state_nxt    = w_flush_pend ? ST_FLUSH : ST_RUN;
            if (w_req == REQ_LU) begin
                w_ctrl.le_pc    = 1'b0;
                w_ctrl.le_if_id = 1'b0;
                w_ctrl.nop      = 1'b0;
            end else if (w_br_accept) begin
                w_ctrl.flush_if_id = 1'b1;
                w_flush_cnt_nxt    = FLUSH_INIT;
                w_state_nxt        = (FLUSH_INIT != '0) ? ST_FLUSH : ST_RUN;
            end
        end
    end

    assign bus.LE_PC       = w_ctrl.le_pc;
    assign bus.LE_IF_ID    = w_ctrl.le_if_id;
    assign bus.FLUSH_IF_ID = w_ctrl.flush_if_id;
    assign bus.NOP         = w_ctrl.nop;
    assign bus.LE_ID_EX    = w_ctrl.le_id_ex;
    assign bus.LE_EX_MEM   = w_ctrl.le_ex_mem;
    assign bus.WB_NOP      = w_ctrl.wb_nop;
    assign bus.mem_timeout = (r_timeout && !reset) || w_timeout_set;
    assign bus.dbg_state   = r_state;

`ifdef STALL_STATS_EN
    logic w_stall_evt;

    assign w_stall_evt = !w_ctrl.le_pc;

    sat_event_counter #(.STAT_W(STAT_W)) u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_stall_evt),
        .o_count (bus.stall_cycles)
    );

    sat_event_counter #(.STAT_W(STAT_W)) u_flush_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_br_accept),
        .o_count (bus.flush_count)
    );
`else
    assign bus.stall_cycles = {STAT_W{1'b0}};
    assign bus.flush_count  = {STAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: directed scenarios plus random traffic,
// each cycle's expected outputs queued by a behavioural model and checked by a monitor.
module tb_pipeline_stall_controller;

    localparam int STAT_W   = 16;
    localparam int MAX_WAIT = 8;
    localparam int BR_CYC   = 2;
    localparam int W        = 1 + 7 + 1 + 2 * STAT_W;
    localparam int STAT_MAX = (2 ** STAT_W) - 1;

    // {LE_PC, LE_IF_ID, FLUSH_IF_ID, NOP, LE_ID_EX, LE_EX_MEM, WB_NOP}
    localparam logic [6:0] C_RESET  = 7'b0010001;
    localparam logic [6:0] C_FREEZE = 7'b0001001;
    localparam logic [6:0] C_RUN    = 7'b1101110;
    localparam logic [6:0] C_STALL  = 7'b0000110;
    localparam logic [6:0] C_FLUSH  = 7'b1111110;

`ifdef STALL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk;
    logic reset;

    pipeline_stall_controller_if #(.STAT_W(STAT_W)) bus ();

    pipeline_stall_controller #(
        .MAX_MEM_WAIT (MAX_WAIT),
        .BR_FLUSH_CYC (BR_CYC),
        .CNT_W        (4),
        .STAT_W       (STAT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: flush cycles still owed, length of the current busy run,
    // sticky timeout and the two statistics totals.
    int m_flush_left = 0;
    int m_busy_run   = 0;
    bit m_timeout    = 1'b0;
    int m_stall      = 0;
    int m_flush      = 0;
    bit m_stats_ok   = 1'b0;

    function automatic int sat_inc(input int v);
        return (v >= STAT_MAX) ? v : v + 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- driver ----------------
    task automatic step(input bit rst, input bit mem, input bit lu, input bit br);
        logic [6:0]        ctrl;
        logic [STAT_W-1:0] es;
        logic [STAT_W-1:0] ef;
        bit                tmo;
        bit                ok;
        reset           = rst;
        bus.mem_busy    = mem;
        bus.hz_load_use = lu;
        bus.br_taken    = br;
        ok = m_stats_ok;
        es = STATS ? STAT_W'(m_stall) : '0;
        ef = STATS ? STAT_W'(m_flush) : '0;
        if (rst) begin
            ctrl = C_RESET;
            tmo  = 1'b0;
            m_flush_left = 0;
            m_busy_run   = 0;
            m_timeout    = 1'b0;
            m_stall      = 0;
            m_flush      = 0;
            m_stats_ok   = 1'b1;
        end else if (mem) begin
            ctrl = C_FREEZE;
            m_busy_run++;
            if (m_busy_run >= MAX_WAIT) m_timeout = 1'b1;
            tmo = m_timeout;
            m_stall = sat_inc(m_stall);
        end else begin
            if (m_flush_left > 0 && m_busy_run == 0) begin
                ctrl = C_FLUSH;
                m_flush_left--;
            end else if (lu) begin
                ctrl = C_STALL;
                m_stall = sat_inc(m_stall);
            end else if (br && m_flush_left == 0) begin
                ctrl = C_FLUSH;
                m_flush_left = BR_CYC - 1;
                m_flush = sat_inc(m_flush);
            end else begin
                ctrl = C_RUN;
            end
            m_busy_run = 0;
            tmo = m_timeout;
        end
        exp_q.push_back({ok, ctrl, tmo, es, ef});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ctrl", 32'({bus.LE_PC, bus.LE_IF_ID, bus.FLUSH_IF_ID, bus.NOP,
                               bus.LE_ID_EX, bus.LE_EX_MEM, bus.WB_NOP}), 32'(e[W-2 -: 7]));
            check("mem_timeout", 32'(bus.mem_timeout), 32'(e[2*STAT_W]));
            if (e[W-1]) begin
                check("stall_cycles", 32'(bus.stall_cycles), 32'(e[2*STAT_W-1:STAT_W]));
                check("flush_count", 32'(bus.flush_count), 32'(e[STAT_W-1:0]));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int mode;
        int len;
        reset           = 1'b1;
        bus.mem_busy    = 1'b0;
        bus.hz_load_use = 1'b0;
        bus.br_taken    = 1'b0;
        @(posedge clk);
        #1;

        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);

        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);

        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Memory wait arriving while a branch flush is still owed.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(3);

        // Load-use and branch together, branch re-presented next cycle.
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Back-to-back branches: the one seen during the flush is ignored.
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);

        for (int k = 0; k < 9; k++) step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);

        // Reset in the middle of a flush and of a wait.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);

        for (int i = 0; i < 400; i++) begin
            mode = $urandom_range(0, 39);
            if (mode == 0) begin
                step(1'b1, 1'b0, 1'b0, 1'b0);
            end else if (mode == 1) begin
                len = $urandom_range(6, 11);
                for (int k = 0; k < len; k++)
                    step(1'b0, 1'b1, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
            end else begin
                step(1'b0, ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
                     ($urandom_range(0, 2) == 0));
            end
        end
        idle(4);

        @(negedge clk);
        #1;
        check("queue_drain", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
